alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised digit-serial ALU. It processes a WIDTH-bit operand pair DIGIT bits per cycle, LSB first, and supports the 3-bit opcode set used by the single-bit ALU slices. It replaces a full-width ripple of bit slices with a shared DIGIT-wide slice and a sequencer, trading latency for area. It sits behind a start/done handshake so a controller can issue one operation at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-high; one clock domain.
- start, input, 1, request; accepted only when busy=0.
- op, input, 3, opcode, sampled with start.
- a, input, WIDTH, operand A, sampled with start.
- b, input, WIDTH, operand B, sampled with start.
- busy, output, 1, operation in flight.
- done, output, 1, one-cycle pulse; result and flags are valid from this cycle.
- result, output, WIDTH, last completed result, held until the next completion.
- carryout, output, 1, final carry (ADD/SUB only, else 0).
- overflow, output, 1, signed overflow (ADD/SUB only, else 0).
- zero, output, 1, result == 0.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- States and transitions:
  - IDLE: on start, latch a, b and op, clear the digit index, go to RUN.
  - RUN: process one digit per cycle. After the last digit (index NDIG−1, NDIG = WIDTH/DIGIT), go to IDLE and pulse done.
- SUB and SLT: b is latched inverted and the carry register is initialised to 1. ADD initialises carry to 0.
- Each RUN cycle:
  - The slice combines a[i*DIGIT+:DIGIT], b' digit and the carry register.
  - The digit result is written into a shift/accumulate register.
  - The carry register takes the digit carry-out.
- Final digit:
  - overflow = carry into MSB XOR carry out of MSB.
  - carryout = carry out of MSB.
- SLT: result = {0…0, sum[MSB] XOR overflow}. carryout and overflow are forced to 0.
- Logic ops: bitwise per digit; carry is ignored; carryout and overflow are 0.
- result, carryout, overflow and zero update only at completion. Partial digits are never visible on result.
- start while busy=1 is ignored; no queuing.

## Timing
- Reset values: busy=0, done=0, result=0, carryout=0, overflow=0, zero=1. State is IDLE and internal registers are cleared.
- If start is high at edge k in IDLE:
  - busy=1 from k+1.
  - Completion occurs at edge k+NDIG: done=1 and busy=0 for that cycle, with outputs updated.
- Latency: NDIG cycles from acceptance to done. Throughput: one operation per NDIG cycles.
- start is accepted in the cycle done is high, so operations can run back to back with no bubble.
- DIGIT == WIDTH gives 1-cycle latency; RUN lasts exactly one cycle.
- Reset asserted mid-RUN aborts the operation: no done pulse, and outputs return to reset values immediately (asynchronously).
- done is never high for two consecutive cycles unless a new operation completes with NDIG=1.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_OR);
  - state encoding (ST_IDLE, ST_RUN).
- Sub-module alu_digit:
  - combinational, DIGIT-wide;
  - inputs: a, b', cin, op;
  - outputs: y, cout, and carry-into-MSB;
  - internally a ripple adder plus a logic-op mux, matching the opcode map.
- Top level contains the sequencer, digit index counter, operand shift registers, carry register, result accumulator and flag logic.

## Test plan
- ADD, WIDTH=32, DIGIT=4: a=0xFFFFFFFF, b=0x00000001 → done 8 cycles after start; result=0, carryout=1, overflow=0, zero=1.
- SUB: a=0x80000000, b=0x00000001 → result=0x7FFFFFFF, overflow=1, carryout=1.
- SLT: a=0xFFFFFFFE (−2), b=0x00000003 → result=1; then a=0x7FFFFFFF, b=0x80000000 → result=0.
- Logic sweep: a=0xF0F0F0F0, b=0xFF00FF00 for ops 2, 4, 5, 6, 7 → 0x0FF00FF0, 0xF000F000, 0x0FFF0FFF, 0x000F000F, 0xFFF0FFF0.
- Handshake:
  - start pulsed mid-RUN is ignored and the result matches the first op;
  - start in the done cycle is accepted, giving back-to-back results 8 cycles apart.
- Reset asserted at RUN cycle 3 → busy=0, result=0, zero=1 immediately; no done pulse. A subsequent ADD completes correctly. Repeat with DIGIT=1 (32-cycle latency) and DIGIT=32 (1-cycle latency).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcode map and sequencer states.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SUB and SLT run through the adder as a + ~b + 1.
    function automatic logic uses_inverted_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// One DIGIT-wide ALU slice: ripple adder plus bitwise logic-op mux.
// Operand b arrives already inverted for SUB/SLT; the caller owns the carry.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    input  logic [2:0]       i_op,
    output logic [DIGIT-1:0] o_y,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT-1:0] w_sum;
    logic [DIGIT:0]   w_c;

    // Ripple-carry sum across the digit; carry into the top bit is kept for overflow.
    always_comb begin
        w_sum  = '0;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < DIGIT; k++) begin
            w_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
            w_c[k+1]  = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
        end
        o_cout = w_c[DIGIT];
        o_cmsb = w_c[DIGIT-1];
    end

    // Select the digit result for the opcode; arithmetic ops share the adder.
    always_comb begin
        o_y = w_sum;
        case (i_op)
            OP_ADD, OP_SUB, OP_SLT: o_y = w_sum;
            OP_XOR:                 o_y = i_a ^ i_b;
            OP_AND:                 o_y = i_a & i_b;
            OP_NAND:                o_y = ~(i_a & i_b);
            OP_NOR:                 o_y = ~(i_a | i_b);
            OP_OR:                  o_y = i_a | i_b;
            default:                o_y = w_sum;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: processes WIDTH-bit operands DIGIT bits per cycle, LSB first.
// Handshake: start is taken only while busy is low (IDLE, including the done
// cycle); done pulses for one cycle when result and flags have been updated.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] r_result;
    logic             r_carryout;
    logic             r_overflow;
    logic             r_zero;
    logic             r_done;

    logic [DIGIT-1:0] w_y;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_ovf_raw;
    logic [WIDTH-1:0] w_y_wide;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_fin_result;
    logic             w_fin_cout;
    logic             w_fin_ovf;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_y    (w_y),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // Sequencer next-state: accept in IDLE, leave RUN after the last digit.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Accumulate the new digit at the top and form the final result and flags.
    always_comb begin
        w_y_wide     = WIDTH'(w_y);
        w_acc_next   = (r_acc >> DIGIT) | (w_y_wide << (WIDTH - DIGIT));
        w_ovf_raw    = w_cmsb ^ w_cout;
        w_fin_result = w_acc_next;
        w_fin_cout   = 1'b0;
        w_fin_ovf    = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_fin_cout = w_cout;
                w_fin_ovf  = w_ovf_raw;
            end
            OP_SLT:  w_fin_result = WIDTH'(w_y[DIGIT-1] ^ w_ovf_raw);
            default: ;
        endcase
    end

    // Operand shift registers, carry, digit index and partial-result accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= uses_inverted_b(op) ? ~b : b;
            r_acc   <= '0;
            r_carry <= uses_inverted_b(op);
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            if (!w_last) r_idx <= r_idx + IDXW'(1);
        end
    end

    // Visible outputs change only at completion, so partial digits never leak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result   <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_result   <= w_fin_result;
                r_carryout <= w_fin_cout;
                r_overflow <= w_fin_ovf;
                r_zero     <= (w_fin_result == '0);
            end
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign done     = r_done;
    assign result   = r_result;
    assign carryout = r_carryout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three instances (DIGIT = 4, 1, 32) at WIDTH = 32,
// directed vector table, randomized ops against an arithmetic reference,
// and hand-written handshake / reset-abort sequences.
module tb_alu_serial;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    logic             clk = 1'b0;
    logic [2:0]       reset_v;
    logic [2:0]       start_v;
    logic [2:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2:0]       busy_w;
    logic [2:0]       done_w;
    logic [2:0]       co_w;
    logic [2:0]       ov_w;
    logic [2:0]       z_w;
    logic [2:0][W-1:0] res_w;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl [9];

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .op(op), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]),
        .carryout(co_w[0]), .overflow(ov_w[0]), .zero(z_w[0])
    );

    alu_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .op(op), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]),
        .carryout(co_w[1]), .overflow(ov_w[1]), .zero(z_w[1])
    );

    alu_serial #(.WIDTH(W), .DIGIT(32)) u_d32 (
        .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .op(op), .a(a), .b(b),
        .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]),
        .carryout(co_w[2]), .overflow(ov_w[2]), .zero(z_w[2])
    );

    function automatic int ndig(input int d);
        if (d == 0) return 8;
        if (d == 1) return 32;
        return 1;
    endfunction

    // Reference: plain two's-complement arithmetic on whole words.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (o)
            3'd0: begin
                s   = {1'b0, x} + {1'b0, y};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'd1: begin
                s   = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'd2: e.r = x ^ y;
            3'd3: e.r = W'($signed(x) < $signed(y));
            3'd4: e.r = x & y;
            3'd5: e.r = ~(x & y);
            3'd6: e.r = ~(x | y);
            default: e.r = x | y;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_out(input int d, input string nm, input exp_t e);
        chk({nm, " result"},   res_w[d],    e.r);
        chk({nm, " carryout"}, W'(co_w[d]), W'(e.c));
        chk({nm, " overflow"}, W'(ov_w[d]), W'(e.v));
        chk({nm, " zero"},     W'(z_w[d]),  W'(e.z));
    endtask

    task automatic check_reset_vals(input int d, input string nm);
        chk({nm, " busy"},     W'(busy_w[d]), '0);
        chk({nm, " done"},     W'(done_w[d]), '0);
        chk({nm, " result"},   res_w[d],      '0);
        chk({nm, " carryout"}, W'(co_w[d]),   '0);
        chk({nm, " overflow"}, W'(ov_w[d]),   '0);
        chk({nm, " zero"},     W'(z_w[d]),    W'(1));
    endtask

    // Waits for done after an accepted start; n counts edges since acceptance.
    task automatic wait_done(input int d, input string nm, input int n0, input exp_t e);
        int  n;
        bit  got;
        n   = n0;
        got = 1'b0;
        while (!got && n < ndig(d) + 4) begin
            @(posedge clk); #1;
            n++;
            if (done_w[d]) got = 1'b1;
        end
        chk({nm, " done seen"}, W'(got), W'(1));
        if (got) begin
            chk({nm, " latency"}, W'(n), W'(ndig(d)));
            chk({nm, " busy at done"}, W'(busy_w[d]), '0);
        end
        check_out(d, nm, e);
    endtask

    // Issue one op; returns #1 after the completion edge (inside the done cycle).
    task automatic run_op(input int d, input logic [2:0] o, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input exp_t e, input string nm);
        @(negedge clk);
        op = o; a = xa; b = xb; start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        chk({nm, " busy after start"}, W'(busy_w[d]), W'(1));
        wait_done(d, nm, 0, e);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] corner [4];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic random_ops(input int d, input int count);
        logic [2:0]   o;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        for (int i = 0; i < count; i++) begin
            o  = 3'($urandom_range(0, 7));
            xa = rand_operand();
            xb = rand_operand();
            run_op(d, o, xa, xb, model(o, xa, xb), $sformatf("rand d%0d #%0d op%0d", d, i, o));
        end
    endtask

    // Abort an in-flight op with reset, then confirm a clean restart.
    task automatic reset_abort(input int d);
        string nm;
        bit    any_done;
        exp_t  e;
        nm = $sformatf("reset_abort d%0d", d);
        run_op(d, OP_ADD, 32'h0000_1234, 32'h1, model(OP_ADD, 32'h0000_1234, 32'h1), {nm, " pre"});
        @(negedge clk);
        op = OP_ADD; a = 32'd10; b = 32'd20; start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        if (ndig(d) >= 3) begin
            repeat (2) @(posedge clk);
            #1;
        end
        reset_v[d] = 1'b1;
        #1;
        check_reset_vals(d, nm);
        @(negedge clk);
        reset_v[d] = 1'b0;
        any_done = 1'b0;
        repeat (ndig(d) + 3) begin
            @(posedge clk); #1;
            if (done_w[d]) any_done = 1'b1;
        end
        chk({nm, " no done after abort"}, W'(any_done), '0);
        chk({nm, " idle after abort"}, W'(busy_w[d]), '0);
        e = model(OP_ADD, 32'h0F0F_0F0F, 32'h1111_1111);
        run_op(d, OP_ADD, 32'h0F0F_0F0F, 32'h1111_1111, e, {nm, " post"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  any_done;
        exp_t e;

        reset_v = 3'b111;
        start_v = 3'b000;
        op = '0; a = '0; b = '0;

        tbl[0] = '{"add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[1] = '{"sub_ovf",   OP_SUB,  32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        tbl[2] = '{"slt_true",  OP_SLT,  32'hFFFF_FFFE, 32'h0000_0003, '{32'h0000_0001, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{"slt_false", OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
        tbl[4] = '{"xor",       OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, '{32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0}};
        tbl[5] = '{"and",       OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 1'b0, 1'b0, 1'b0}};
        tbl[6] = '{"nand",      OP_NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0}};
        tbl[7] = '{"nor",       OP_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, '{32'h000F_000F, 1'b0, 1'b0, 1'b0}};
        tbl[8] = '{"or",        OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0}};

        #2;
        for (int d = 0; d < 3; d++) check_reset_vals(d, $sformatf("reset d%0d", d));
        @(negedge clk);
        reset_v = 3'b000;

        // Directed vectors on every digit width.
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 9; i++)
                run_op(d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e,
                       $sformatf("vec d%0d %s", d, tbl[i].name));

        // Start pulsed mid-RUN is ignored and not queued.
        @(negedge clk);
        op = OP_ADD; a = 32'd1; b = 32'd2; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        op = OP_SUB; a = 32'd100; b = 32'd5; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("midrun busy", W'(busy_w[0]), W'(1));
        chk("midrun no early done", W'(done_w[0]), '0);
        wait_done(0, "midrun ignored", 3, model(OP_ADD, 32'd1, 32'd2));
        any_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_w[0] || busy_w[0]) any_done = 1'b1;
        end
        chk("midrun not queued", W'(any_done), '0);

        // Start raised in the done cycle is accepted immediately.
        run_op(0, OP_ADD, 32'd5, 32'd6, model(OP_ADD, 32'd5, 32'd6), "b2b first");
        op = OP_SUB; a = 32'd3; b = 32'd9; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("b2b accepted busy", W'(busy_w[0]), W'(1));
        chk("b2b done single pulse", W'(done_w[0]), '0);
        chk("b2b result held", res_w[0], 32'd11);
        wait_done(0, "b2b second", 0, model(OP_SUB, 32'd3, 32'd9));

        // Randomized ops against the reference.
        random_ops(0, 40);
        random_ops(1, 8);
        random_ops(2, 30);

        // Asynchronous abort on each digit width.
        for (int d = 0; d < 3; d++) reset_abort(d);

        n = 0;
        e = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
